// File: rtl/seg_display_pkg.sv
// Shared glyph codes, frame modes, segment patterns and FSM states for the status display.
package seg_display_pkg;

    typedef enum logic [1:0] {StIdle, StConvert, StCommit} state_e;

    localparam logic [1:0] ModeBlank = 2'd0;
    localparam logic [1:0] ModeText  = 2'd1;
    localparam logic [1:0] ModeNum   = 2'd2;

    // Codes 0-9 are the decimal digits themselves.
    localparam logic [4:0] GlyphA     = 5'd10;
    localparam logic [4:0] GlyphB     = 5'd11;
    localparam logic [4:0] GlyphD     = 5'd12;
    localparam logic [4:0] GlyphE     = 5'd13;
    localparam logic [4:0] GlyphI     = 5'd14;
    localparam logic [4:0] GlyphJ     = 5'd15;
    localparam logic [4:0] GlyphL     = 5'd16;
    localparam logic [4:0] GlyphO     = 5'd17;
    localparam logic [4:0] GlyphP     = 5'd18;
    localparam logic [4:0] GlyphR     = 5'd19;
    localparam logic [4:0] GlyphS     = 5'd20;
    localparam logic [4:0] GlyphT     = 5'd21;
    localparam logic [4:0] GlyphY     = 5'd22;
    localparam logic [4:0] GlyphDash  = 5'd23;
    localparam logic [4:0] GlyphBlank = 5'd31;

    // Active-low, bit 6 = a ... bit 0 = g.
    localparam logic [6:0] Seg0     = 7'b0000001;
    localparam logic [6:0] Seg1     = 7'b1001111;
    localparam logic [6:0] Seg2     = 7'b0010010;
    localparam logic [6:0] Seg3     = 7'b0000110;
    localparam logic [6:0] Seg4     = 7'b1001100;
    localparam logic [6:0] Seg5     = 7'b0100100;
    localparam logic [6:0] Seg6     = 7'b0100000;
    localparam logic [6:0] Seg7     = 7'b0001111;
    localparam logic [6:0] Seg8     = 7'b0000000;
    localparam logic [6:0] Seg9     = 7'b0000100;
    localparam logic [6:0] SegA     = 7'b0001000;
    localparam logic [6:0] SegB     = 7'b1100000;
    localparam logic [6:0] SegD     = 7'b1000010;
    localparam logic [6:0] SegE     = 7'b0110000;
    localparam logic [6:0] SegI     = 7'b1101111;
    localparam logic [6:0] SegJ     = 7'b1000011;
    localparam logic [6:0] SegL     = 7'b1110001;
    localparam logic [6:0] SegO     = 7'b1100010;
    localparam logic [6:0] SegP     = 7'b0011000;
    localparam logic [6:0] SegR     = 7'b1111010;
    localparam logic [6:0] SegS     = 7'b0100100;
    localparam logic [6:0] SegT     = 7'b1110000;
    localparam logic [6:0] SegY     = 7'b1000100;
    localparam logic [6:0] SegDash  = 7'b1111110;
    localparam logic [6:0] SegBlank = 7'b1111111;

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_status_display_glyph_to_seg.sv
// Combinational glyph-code to active-low seven-segment lookup; unknown codes are blank.
module glyph_to_seg
    import seg_display_pkg::*;
(
    input  logic [4:0] glyph_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SegBlank;
        case (glyph_i)
            5'd0:      seg_o = Seg0;
            5'd1:      seg_o = Seg1;
            5'd2:      seg_o = Seg2;
            5'd3:      seg_o = Seg3;
            5'd4:      seg_o = Seg4;
            5'd5:      seg_o = Seg5;
            5'd6:      seg_o = Seg6;
            5'd7:      seg_o = Seg7;
            5'd8:      seg_o = Seg8;
            5'd9:      seg_o = Seg9;
            GlyphA:    seg_o = SegA;
            GlyphB:    seg_o = SegB;
            GlyphD:    seg_o = SegD;
            GlyphE:    seg_o = SegE;
            GlyphI:    seg_o = SegI;
            GlyphJ:    seg_o = SegJ;
            GlyphL:    seg_o = SegL;
            GlyphO:    seg_o = SegO;
            GlyphP:    seg_o = SegP;
            GlyphR:    seg_o = SegR;
            GlyphS:    seg_o = SegS;
            GlyphT:    seg_o = SegT;
            GlyphY:    seg_o = SegY;
            GlyphDash: seg_o = SegDash;
            default:   seg_o = SegBlank;
        endcase
    end

endmodule

// File: rtl/seg_status_display.sv
// Status prefix plus per-channel decimal readout; a sequential double-dabble builds each
// frame in fixed time and the frame is committed atomically to the active-low pins.
module seg_status_display
    import seg_display_pkg::*;
#(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned VAL_W      = 5,
    parameter int unsigned DIG_PER_CH = 2,
    parameter int unsigned PFX_DIG    = 2,
    parameter int unsigned BLINK_HALF = 25_000_000,
    localparam int unsigned N_DIG     = PFX_DIG + NUM_CH * DIG_PER_CH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      update,
    input  logic [1:0]                mode,
    input  logic [5*N_DIG-1:0]        glyphs,
    input  logic [VAL_W*NUM_CH-1:0]   values,
    input  logic                      lz_blank,
    input  logic                      blink_en,
    output logic                      busy,
    output logic [7*N_DIG-1:0]        seg
);

    localparam int unsigned BCD_W = 4 * DIG_PER_CH;
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned BIT_W = (VAL_W > 1) ? $clog2(VAL_W) : 1;
    localparam int unsigned CNT_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam longint unsigned Limit = pow10(DIG_PER_CH);

    state_e state_q, state_d;
    logic   pending_q, pending_d;
    logic   capture, commit;

    logic [1:0]              mode_q;
    logic [5*N_DIG-1:0]      glyphs_q;
    logic [VAL_W*NUM_CH-1:0] vals_q;
    logic                    lz_q, blink_s_q;

    logic [CH_W-1:0]         ch_q;
    logic [BIT_W-1:0]        bit_q;
    logic [VAL_W-1:0]        sh_q, cur_val, operand;
    logic [BCD_W-1:0]        bcd_q, bcd_in, bcd_adj, bcd_next;
    logic [NUM_CH*BCD_W-1:0] res_q;
    logic                    last_bit, last_ch;
    logic [NUM_CH-1:0]       ovf;

    logic [7*N_DIG-1:0] frame_q, frame_d, frame_nxt, seg_q, seg_d;
    logic               blink_q, blink_d, phase_q, phase_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    assign last_bit = (bit_q == BIT_W'(VAL_W - 1));
    assign last_ch  = (ch_q == CH_W'(NUM_CH - 1));

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        capture   = 1'b0;
        commit    = 1'b0;
        case (state_q)
            StIdle: begin
                if (update) begin
                    capture = 1'b1;
                    state_d = StConvert;
                end
            end
            StConvert: begin
                if (update) pending_d = 1'b1;
                if (last_bit && last_ch) state_d = StCommit;
            end
            StCommit: begin
                commit    = 1'b1;
                pending_d = 1'b0;
                // An update landing on the commit edge is folded into the restart.
                if (pending_q || update) begin
                    capture = 1'b1;
                    state_d = StConvert;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Double-dabble step: the first bit of each channel reloads operand and clears BCD.
    always_comb begin
        cur_val = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_q == CH_W'(c)) cur_val = vals_q[c*VAL_W +: VAL_W];
        end
    end

    assign operand = (bit_q == '0) ? cur_val : sh_q;
    assign bcd_in  = (bit_q == '0) ? '0 : bcd_q;

    always_comb begin
        bcd_adj = bcd_in;
        for (int j = 0; j < DIG_PER_CH; j++) begin
            if (bcd_in[4*j +: 4] >= 4'd5) bcd_adj[4*j +: 4] = bcd_in[4*j +: 4] + 4'd3;
        end
    end

    assign bcd_next = {bcd_adj[BCD_W-2:0], operand[VAL_W-1]};

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ovf
        assign ovf[c] = (64'(vals_q[c*VAL_W +: VAL_W]) >= Limit);
    end

    for (genvar k = 0; k < N_DIG; k++) begin : g_dig
        logic [4:0] code;
        if (k >= NUM_CH * DIG_PER_CH) begin : g_pfx
            always_comb begin
                code = GlyphBlank;
                case (mode_q)
                    ModeText, ModeNum: code = glyphs_q[5*k +: 5];
                    ModeBlank:         code = GlyphBlank;
                    default:           code = GlyphBlank;
                endcase
            end
        end else begin : g_num
            localparam int unsigned Ch = k / DIG_PER_CH;
            localparam int unsigned J  = k % DIG_PER_CH;
            logic [3:0] bcd_dig;
            logic       upper_zero;
            assign bcd_dig    = res_q[Ch*BCD_W + 4*J +: 4];
            assign upper_zero = (res_q[Ch*BCD_W + 4*J +: BCD_W - 4*J] == '0);
            always_comb begin
                code = GlyphBlank;
                case (mode_q)
                    ModeText: code = glyphs_q[5*k +: 5];
                    ModeNum: begin
                        if (ovf[Ch])                          code = GlyphDash;
                        else if (lz_q && J != 0 && upper_zero) code = GlyphBlank;
                        else                                  code = {1'b0, bcd_dig};
                    end
                    default: code = GlyphBlank;
                endcase
            end
        end
        glyph_to_seg u_glyph_to_seg (
            .glyph_i (code),
            .seg_o   (frame_nxt[7*k +: 7])
        );
    end

    // seg is computed from next-state values so it changes on the same edge as the frame.
    always_comb begin
        frame_d = frame_q;
        blink_d = blink_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        if (commit) begin
            frame_d = frame_nxt;
            blink_d = blink_s_q;
            phase_d = 1'b1;
            cnt_d   = '0;
        end else if (cnt_q == CNT_W'(BLINK_HALF - 1)) begin
            phase_d = ~phase_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        seg_d = (blink_d && !phase_d) ? '1 : frame_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            pending_q <= 1'b0;
            mode_q    <= ModeBlank;
            glyphs_q  <= '1;
            vals_q    <= '0;
            lz_q      <= 1'b0;
            blink_s_q <= 1'b0;
            ch_q      <= '0;
            bit_q     <= '0;
            sh_q      <= '0;
            bcd_q     <= '0;
            res_q     <= '0;
            frame_q   <= '1;
            blink_q   <= 1'b0;
            phase_q   <= 1'b1;
            cnt_q     <= '0;
            seg_q     <= '1;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            frame_q   <= frame_d;
            blink_q   <= blink_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            seg_q     <= seg_d;
            if (capture) begin
                mode_q    <= mode;
                glyphs_q  <= glyphs;
                vals_q    <= values;
                lz_q      <= lz_blank;
                blink_s_q <= blink_en;
                ch_q      <= '0;
                bit_q     <= '0;
            end else if (state_q == StConvert) begin
                sh_q  <= operand << 1;
                bcd_q <= bcd_next;
                if (last_bit) begin
                    bit_q <= '0;
                    ch_q  <= ch_q + CH_W'(1);
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (ch_q == CH_W'(c)) res_q[c*BCD_W +: BCD_W] <= bcd_next;
                    end
                end else begin
                    bit_q <= bit_q + BIT_W'(1);
                end
            end
        end
    end

    assign busy = (state_q != StIdle);
    assign seg  = seg_q;

endmodule
